axi_port_arbiter: RTL and testbench

AXI_PORT_ARBITER -- requirements
Module: axi_port_arbiter

---
 rtl/axi_arb_pkg.sv | 8 +
 rtl/wr_order_fifo.sv | 44 ++++
 rtl/axi_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_axi_port_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared widths, FSM state type and the requester-tag bit position
package axi_arb_pkg;
   localparam int ID_W = 8;
   localparam int ADDR_W = 32;
   localparam int LEN_W = 8;
   localparam int REQ_BIT = 7;
   typedef enum logic {IDLE, BUSY} state_e;
endpackage

// File: rtl/wr_order_fifo.sv
// wr_order_fifo: 1-bit FIFO recording which requester owns each granted write burst
module wr_order_fifo #(
   parameter int DEPTH = 4,
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic          din_i,
   input  logic          pop_i,
   output logic          head_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);
   logic          mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q;
   logic          do_push, do_pop;
   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction
   assign do_push = push_i && !full_o;
   assign do_pop = pop_i && !empty_o;
   assign full_o = cnt_q == CW'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign count_o = cnt_q;
   assign head_o = mem_q[rd_q];
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= din_i;
            wr_q <= nxt(wr_q);
         end
         if (do_pop) rd_q <= nxt(rd_q);
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/axi_port_arbiter.sv
// axi_port_arbiter: two-requester round-robin arbiter onto one AXI port,
// with write data ordered by grant and responses routed by the id tag bit
module axi_port_arbiter
   import axi_arb_pkg::*;
#(
   parameter int DW = 256,
   parameter int WFIFO_DEPTH = 4
) (
   input  logic              axi_clk,
   input  logic              rst,
   input  logic [ID_W-1:0]   s0_aid,
   input  logic [ADDR_W-1:0] s0_aaddr,
   input  logic [LEN_W-1:0]  s0_alen,
   input  logic [2:0]        s0_asize,
   input  logic [1:0]        s0_aburst,
   input  logic [1:0]        s0_alock,
   input  logic              s0_atype,
   input  logic              s0_avalid,
   output logic              s0_aready,
   input  logic [ID_W-1:0]   s0_wid,
   input  logic [DW-1:0]     s0_wdata,
   input  logic [DW/8-1:0]   s0_wstrb,
   input  logic              s0_wlast,
   input  logic              s0_wvalid,
   output logic              s0_wready,
   output logic [ID_W-1:0]   s0_rid,
   output logic [DW-1:0]     s0_rdata,
   output logic [1:0]        s0_rresp,
   output logic              s0_rlast,
   output logic              s0_rvalid,
   input  logic              s0_rready,
   output logic [ID_W-1:0]   s0_bid,
   output logic              s0_bvalid,
   input  logic              s0_bready,
   input  logic [ID_W-1:0]   s1_aid,
   input  logic [ADDR_W-1:0] s1_aaddr,
   input  logic [LEN_W-1:0]  s1_alen,
   input  logic [2:0]        s1_asize,
   input  logic [1:0]        s1_aburst,
   input  logic [1:0]        s1_alock,
   input  logic              s1_atype,
   input  logic              s1_avalid,
   output logic              s1_aready,
   input  logic [ID_W-1:0]   s1_wid,
   input  logic [DW-1:0]     s1_wdata,
   input  logic [DW/8-1:0]   s1_wstrb,
   input  logic              s1_wlast,
   input  logic              s1_wvalid,
   output logic              s1_wready,
   output logic [ID_W-1:0]   s1_rid,
   output logic [DW-1:0]     s1_rdata,
   output logic [1:0]        s1_rresp,
   output logic              s1_rlast,
   output logic              s1_rvalid,
   input  logic              s1_rready,
   output logic [ID_W-1:0]   s1_bid,
   output logic              s1_bvalid,
   input  logic              s1_bready,
   output logic [ID_W-1:0]   m_aid,
   output logic [ADDR_W-1:0] m_aaddr,
   output logic [LEN_W-1:0]  m_alen,
   output logic [2:0]        m_asize,
   output logic [1:0]        m_aburst,
   output logic [1:0]        m_alock,
   output logic              m_atype,
   output logic              m_avalid,
   input  logic              m_aready,
   output logic [ID_W-1:0]   m_wid,
   output logic [DW-1:0]     m_wdata,
   output logic [DW/8-1:0]   m_wstrb,
   output logic              m_wlast,
   output logic              m_wvalid,
   input  logic              m_wready,
   input  logic [ID_W-1:0]   m_rid,
   input  logic [DW-1:0]     m_rdata,
   input  logic [1:0]        m_rresp,
   input  logic              m_rlast,
   input  logic              m_rvalid,
   output logic              m_rready,
   input  logic [ID_W-1:0]   m_bid,
   input  logic              m_bvalid,
   output logic              m_bready,
   output logic              busy
);
   localparam int CW = $clog2(WFIFO_DEPTH + 1);
   state_e          state_q;
   logic            sel_q, last_q, sel_d;
   logic            a_ok, push, pop, f_head, f_full, f_empty, w_act, rp, bp, unused_bits;
   logic [CW-1:0]   f_count;
   assign sel_d = (s0_avalid && s1_avalid) ? !last_q : s1_avalid;
   always_ff @(posedge axi_clk) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q <= 1'b0;
         last_q <= 1'b1;
      end else if (state_q == IDLE) begin
         if (s0_avalid || s1_avalid) begin
            sel_q <= sel_d;
            last_q <= sel_d;
            state_q <= BUSY;
         end
      end else if (m_avalid && m_aready) begin
         state_q <= IDLE;
      end
   end
   // a full order FIFO holds back write commands only; reads still pass
   assign m_atype = sel_q ? s1_atype : s0_atype;
   assign a_ok = state_q == BUSY && !(m_atype && f_full);
   assign m_avalid = a_ok && (sel_q ? s1_avalid : s0_avalid);
   assign s0_aready = a_ok && !sel_q && m_aready;
   assign s1_aready = a_ok && sel_q && m_aready;
   assign m_aid = {sel_q, sel_q ? s1_aid[REQ_BIT-1:0] : s0_aid[REQ_BIT-1:0]};
   assign m_aaddr = sel_q ? s1_aaddr : s0_aaddr;
   assign m_alen = sel_q ? s1_alen : s0_alen;
   assign m_asize = sel_q ? s1_asize : s0_asize;
   assign m_aburst = sel_q ? s1_aburst : s0_aburst;
   assign m_alock = sel_q ? s1_alock : s0_alock;
   assign push = m_avalid && m_aready && m_atype;
   assign pop = m_wvalid && m_wready && m_wlast;
   wr_order_fifo #(.DEPTH(WFIFO_DEPTH)) u_fifo (
      .clk_i(axi_clk), .rst_i(rst), .push_i(push), .din_i(sel_q), .pop_i(pop),
      .head_o(f_head), .full_o(f_full), .empty_o(f_empty), .count_o(f_count)
   );
   assign w_act = !f_empty;
   assign m_wvalid = w_act && (f_head ? s1_wvalid : s0_wvalid);
   assign s0_wready = w_act && !f_head && m_wready;
   assign s1_wready = w_act && f_head && m_wready;
   assign m_wid = {f_head, f_head ? s1_wid[REQ_BIT-1:0] : s0_wid[REQ_BIT-1:0]};
   assign m_wdata = f_head ? s1_wdata : s0_wdata;
   assign m_wstrb = f_head ? s1_wstrb : s0_wstrb;
   assign m_wlast = f_head ? s1_wlast : s0_wlast;
   assign busy = state_q == BUSY || w_act;
   assign rp = m_rid[REQ_BIT];
   assign bp = m_bid[REQ_BIT];
   assign s0_rvalid = m_rvalid && !rp;
   assign s1_rvalid = m_rvalid && rp;
   assign m_rready = rp ? s1_rready : s0_rready;
   assign s0_rid = {1'b0, m_rid[REQ_BIT-1:0]};
   assign s1_rid = {1'b0, m_rid[REQ_BIT-1:0]};
   assign s0_rdata = m_rdata;
   assign s1_rdata = m_rdata;
   assign s0_rresp = m_rresp;
   assign s1_rresp = m_rresp;
   assign s0_rlast = m_rlast;
   assign s1_rlast = m_rlast;
   assign s0_bvalid = m_bvalid && !bp;
   assign s1_bvalid = m_bvalid && bp;
   assign m_bready = bp ? s1_bready : s0_bready;
   assign s0_bid = {1'b0, m_bid[REQ_BIT-1:0]};
   assign s1_bid = {1'b0, m_bid[REQ_BIT-1:0]};
   assign unused_bits = ^{s0_aid[REQ_BIT], s1_aid[REQ_BIT], s0_wid[REQ_BIT], s1_wid[REQ_BIT], f_count};
endmodule

// File: tb/tb_axi_port_arbiter.sv
// tb_axi_port_arbiter: directed and randomized checks of arbitration, write ordering and response routing
module tb_axi_port_arbiter;
   localparam int DW = 32;
   logic axi_clk = 1'b0;
   logic rst = 1'b1;
   logic [7:0] s_aid [2];
   logic [31:0] s_aaddr [2];
   logic [7:0] s_alen [2];
   logic [2:0] s_asize [2];
   logic [1:0] s_aburst [2], s_alock [2];
   logic s_atype [2], s_avalid [2], s_aready [2];
   logic [7:0] s_wid [2];
   logic [DW-1:0] s_wdata [2];
   logic [DW/8-1:0] s_wstrb [2];
   logic s_wlast [2], s_wvalid [2], s_wready [2];
   logic [7:0] s_rid [2];
   logic [DW-1:0] s_rdata [2];
   logic [1:0] s_rresp [2];
   logic s_rlast [2], s_rvalid [2], s_rready [2];
   logic [7:0] s_bid [2];
   logic s_bvalid [2], s_bready [2];
   logic [7:0] m_aid, m_alen, m_wid, m_rid, m_bid;
   logic [31:0] m_aaddr;
   logic [2:0] m_asize;
   logic [1:0] m_aburst, m_alock, m_rresp;
   logic m_atype, m_avalid, m_aready;
   logic [DW-1:0] m_wdata, m_rdata;
   logic [DW/8-1:0] m_wstrb;
   logic m_wlast, m_wvalid, m_wready, m_rlast, m_rvalid, m_rready, m_bvalid, m_bready, busy;
   int n_vec = 0, n_err = 0;
   int q[$];
   int beat [2];
   int h, nb;
   logic [7:0] rid, bid;
   logic [DW-1:0] rdata;
   logic rv, bv, p, bq;

   axi_port_arbiter #(.DW(DW), .WFIFO_DEPTH(4)) dut (
      .axi_clk(axi_clk), .rst(rst),
      .s0_aid(s_aid[0]), .s0_aaddr(s_aaddr[0]), .s0_alen(s_alen[0]), .s0_asize(s_asize[0]),
      .s0_aburst(s_aburst[0]), .s0_alock(s_alock[0]), .s0_atype(s_atype[0]),
      .s0_avalid(s_avalid[0]), .s0_aready(s_aready[0]),
      .s0_wid(s_wid[0]), .s0_wdata(s_wdata[0]), .s0_wstrb(s_wstrb[0]), .s0_wlast(s_wlast[0]),
      .s0_wvalid(s_wvalid[0]), .s0_wready(s_wready[0]),
      .s0_rid(s_rid[0]), .s0_rdata(s_rdata[0]), .s0_rresp(s_rresp[0]), .s0_rlast(s_rlast[0]),
      .s0_rvalid(s_rvalid[0]), .s0_rready(s_rready[0]),
      .s0_bid(s_bid[0]), .s0_bvalid(s_bvalid[0]), .s0_bready(s_bready[0]),
      .s1_aid(s_aid[1]), .s1_aaddr(s_aaddr[1]), .s1_alen(s_alen[1]), .s1_asize(s_asize[1]),
      .s1_aburst(s_aburst[1]), .s1_alock(s_alock[1]), .s1_atype(s_atype[1]),
      .s1_avalid(s_avalid[1]), .s1_aready(s_aready[1]),
      .s1_wid(s_wid[1]), .s1_wdata(s_wdata[1]), .s1_wstrb(s_wstrb[1]), .s1_wlast(s_wlast[1]),
      .s1_wvalid(s_wvalid[1]), .s1_wready(s_wready[1]),
      .s1_rid(s_rid[1]), .s1_rdata(s_rdata[1]), .s1_rresp(s_rresp[1]), .s1_rlast(s_rlast[1]),
      .s1_rvalid(s_rvalid[1]), .s1_rready(s_rready[1]),
      .s1_bid(s_bid[1]), .s1_bvalid(s_bvalid[1]), .s1_bready(s_bready[1]),
      .m_aid(m_aid), .m_aaddr(m_aaddr), .m_alen(m_alen), .m_asize(m_asize), .m_aburst(m_aburst),
      .m_alock(m_alock), .m_atype(m_atype), .m_avalid(m_avalid), .m_aready(m_aready),
      .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
      .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
      .m_rvalid(m_rvalid), .m_rready(m_rready),
      .m_bid(m_bid), .m_bvalid(m_bvalid), .m_bready(m_bready), .busy(busy)
   );

   always #5 axi_clk = ~axi_clk;

   task automatic tick();
      @(posedge axi_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_all();
      for (int n = 0; n < 2; n++) begin
         s_aid[n] = '0; s_aaddr[n] = '0; s_alen[n] = '0; s_asize[n] = '0;
         s_aburst[n] = '0; s_alock[n] = '0; s_atype[n] = 1'b0; s_avalid[n] = 1'b0;
         s_wid[n] = '0; s_wdata[n] = '0; s_wstrb[n] = '0; s_wlast[n] = 1'b0; s_wvalid[n] = 1'b0;
         s_rready[n] = 1'b0; s_bready[n] = 1'b0;
      end
      m_aready = 1'b0; m_wready = 1'b0;
      m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
      m_bid = '0; m_bvalid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic rnd_cmd(input int n, input logic wr, input logic [7:0] len);
      s_aid[n] = {1'b0, 7'($urandom)};
      s_aaddr[n] = $urandom;
      s_alen[n] = len;
      s_asize[n] = 3'($urandom);
      s_aburst[n] = 2'($urandom);
      s_alock[n] = 2'($urandom);
      s_atype[n] = wr;
   endtask

   task automatic rnd_w(input int n);
      s_wid[n] = {1'b0, 7'($urandom)};
      s_wdata[n] = $urandom;
      s_wstrb[n] = 4'($urandom);
      s_wlast[n] = beat[n] == int'(s_alen[n]);
   endtask

   task automatic wait_hs(input string tag);
      logic seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge axi_clk);
         seen = m_avalid && m_aready;
      end
      chk({tag, "_handshake"}, seen, 1);
   endtask

   initial begin
      idle_all();
      s_avalid[0] = 1'b1; s_avalid[1] = 1'b1; s_wvalid[0] = 1'b1; s_wvalid[1] = 1'b1;
      tick();
      tick();
      @(negedge axi_clk);
      chk("rst_m_avalid", m_avalid, 0);
      chk("rst_s0_aready", s_aready[0], 0);
      chk("rst_s1_aready", s_aready[1], 0);
      chk("rst_m_wvalid", m_wvalid, 0);
      chk("rst_s0_wready", s_wready[0], 0);
      chk("rst_s1_wready", s_wready[1], 0);
      chk("rst_busy", busy, 0);
      tick();
      idle_all();
      rst = 1'b0;
      rnd_cmd(0, 1'b0, 8'd7);
      s_aaddr[0] = 32'h100;
      m_aready = 1'b1;
      s_avalid[0] = 1'b1;
      @(negedge axi_clk);
      chk("bubble_m_avalid", m_avalid, 0);
      chk("bubble_s0_aready", s_aready[0], 0);
      tick();
      @(negedge axi_clk);
      chk("rd_m_avalid", m_avalid, 1);
      chk("rd_m_aid", m_aid, {1'b0, s_aid[0][6:0]});
      chk("rd_m_aaddr", m_aaddr, 32'h100);
      chk("rd_m_alen", m_alen, 7);
      chk("rd_m_asize", m_asize, s_asize[0]);
      chk("rd_m_atype", m_atype, 0);
      chk("rd_s0_aready", s_aready[0], 1);
      chk("rd_s1_aready", s_aready[1], 0);
      chk("rd_busy", busy, 1);
      tick();
      s_avalid[0] = 1'b0;
      s_rready[0] = 1'b1;
      for (int b = 0; b < 8; b++) begin
         rid = {1'b0, 7'($urandom)};
         rdata = $urandom;
         m_rid = rid; m_rdata = rdata; m_rvalid = 1'b1; m_rlast = b == 7;
         @(negedge axi_clk);
         chk("beat_s0_rvalid", s_rvalid[0], 1);
         chk("beat_s1_rvalid", s_rvalid[1], 0);
         chk("beat_s0_rlast", s_rlast[0], b == 7);
         chk("beat_s0_rdata", s_rdata[0], rdata);
         chk("beat_s0_rid", s_rid[0], rid);
         chk("beat_m_rready", m_rready, 1);
         tick();
      end
      m_rvalid = 1'b0; m_rlast = 1'b0;
      for (int i = 0; i < 40; i++) begin
         rid = 8'($urandom); bid = 8'($urandom); rdata = $urandom;
         rv = 1'($urandom); bv = 1'($urandom);
         m_rid = rid; m_rdata = rdata; m_rvalid = rv; m_rresp = 2'($urandom);
         m_bid = bid; m_bvalid = bv;
         s_rready[0] = 1'($urandom); s_rready[1] = 1'($urandom);
         s_bready[0] = 1'($urandom); s_bready[1] = 1'($urandom);
         p = rid[7];
         bq = bid[7];
         @(negedge axi_clk);
         chk("rt_rvalid_sel", s_rvalid[p], rv);
         chk("rt_rvalid_other", s_rvalid[!p], 0);
         chk("rt_m_rready", m_rready, s_rready[p]);
         chk("rt_rid", s_rid[p], {1'b0, rid[6:0]});
         chk("rt_rdata_fanout", s_rdata[!p], rdata);
         chk("rt_rresp_fanout", s_rresp[!p], m_rresp);
         chk("rt_bvalid_sel", s_bvalid[bq], bv);
         chk("rt_bvalid_other", s_bvalid[!bq], 0);
         chk("rt_m_bready", m_bready, s_bready[bq]);
         chk("rt_bid", s_bid[bq], {1'b0, bid[6:0]});
         tick();
      end
      idle_all();
      m_bid = 8'h85; m_bvalid = 1'b1; s_bready[1] = 1'b1;
      @(negedge axi_clk);
      chk("b85_s1_bvalid", s_bvalid[1], 1);
      chk("b85_s1_bid", s_bid[1], 8'h05);
      chk("b85_s0_bvalid", s_bvalid[0], 0);
      chk("b85_m_bready_hi", m_bready, 1);
      tick();
      s_bready[1] = 1'b0;
      s_bready[0] = 1'b1;
      @(negedge axi_clk);
      chk("b85_m_bready_lo", m_bready, 0);
      tick();
      idle_all();
      do_reset();
      rnd_cmd(0, 1'b0, 8'($urandom));
      rnd_cmd(1, 1'b0, 8'($urandom));
      s_avalid[0] = 1'b1; s_avalid[1] = 1'b1; m_aready = 1'b1;
      for (int g = 0; g < 6; g++) begin
         h = g % 2;
         wait_hs("arb");
         chk("arb_m_aid7", m_aid[7], h);
         chk("arb_m_aaddr", m_aaddr, s_aaddr[h]);
         chk("arb_win_aready", s_aready[h], 1);
         chk("arb_lose_aready", s_aready[1-h], 0);
         tick();
         rnd_cmd(h, 1'b0, 8'($urandom));
      end
      idle_all();
      do_reset();
      m_aready = 1'b1; m_wready = 1'b1;
      rnd_cmd(1, 1'b1, 8'd3);
      s_avalid[1] = 1'b1;
      wait_hs("wr_s1");
      chk("wr_s1_aid7", m_aid[7], 1);
      chk("wr_s1_atype", m_atype, 1);
      tick();
      s_avalid[1] = 1'b0;
      rnd_cmd(0, 1'b1, 8'd7);
      s_avalid[0] = 1'b1;
      wait_hs("wr_s0");
      chk("wr_s0_aid7", m_aid[7], 0);
      tick();
      s_avalid[0] = 1'b0;
      @(negedge axi_clk);
      chk("wr_fifo_count2", dut.u_fifo.count_o, 2);
      chk("wr_busy_pending", busy, 1);
      chk("wr_m_wvalid_idle", m_wvalid, 0);
      tick();
      q = '{1, 0};
      nb = 0;
      for (int n = 0; n < 2; n++) begin
         beat[n] = 0;
         s_wvalid[n] = 1'b1;
         rnd_w(n);
      end
      for (int i = 0; i < 20 && q.size() > 0; i++) begin
         h = q[0];
         @(negedge axi_clk);
         chk("wd_m_wvalid", m_wvalid, 1);
         chk("wd_m_wid", m_wid, {h[0], s_wid[h][6:0]});
         chk("wd_m_wdata", m_wdata, s_wdata[h]);
         chk("wd_m_wlast", m_wlast, s_wlast[h]);
         chk("wd_owner_wready", s_wready[h], 1);
         chk("wd_other_wready", s_wready[1-h], 0);
         tick();
         nb++;
         if (s_wlast[h]) begin
            void'(q.pop_front());
            s_wvalid[h] = 1'b0;
         end else begin
            beat[h]++;
            rnd_w(h);
         end
      end
      @(negedge axi_clk);
      chk("wd_total_beats", nb, 12);
      chk("wd_fifo_count0", dut.u_fifo.count_o, 0);
      chk("wd_busy_done", busy, 0);
      chk("wd_m_wvalid_done", m_wvalid, 0);
      tick();
      idle_all();
      do_reset();
      m_aready = 1'b1; m_wready = 1'b1;
      rnd_cmd(0, 1'b1, 8'd0);
      s_avalid[0] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_hs("full_fill");
         tick();
         rnd_cmd(0, 1'b1, 8'd0);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge axi_clk);
         chk("full_m_avalid", m_avalid, 0);
         chk("full_s0_aready", s_aready[0], 0);
         chk("full_busy", busy, 1);
         tick();
      end
      beat[0] = 0;
      s_wvalid[0] = 1'b1;
      rnd_w(0);
      @(negedge axi_clk);
      chk("full_pop_wvalid", m_wvalid, 1);
      chk("full_pop_wlast", m_wlast, 1);
      chk("full_pop_aready", s_aready[0], 0);
      tick();
      s_wvalid[0] = 1'b0;
      @(negedge axi_clk);
      chk("full_5th_avalid", m_avalid, 1);
      chk("full_5th_aready", s_aready[0], 1);
      tick();
      idle_all();
      do_reset();
      m_aready = 1'b1;
      rnd_cmd(1, 1'b1, 8'd1);
      s_avalid[1] = 1'b1;
      wait_hs("mid_s1");
      tick();
      s_avalid[1] = 1'b0;
      rnd_cmd(0, 1'b1, 8'd1);
      s_avalid[0] = 1'b1;
      wait_hs("mid_s0");
      tick();
      s_avalid[0] = 1'b0;
      m_aready = 1'b0;
      rnd_cmd(1, 1'b0, 8'd0);
      s_avalid[1] = 1'b1;
      tick();
      @(negedge axi_clk);
      chk("mid_busy", busy, 1);
      chk("mid_count2", dut.u_fifo.count_o, 2);
      chk("mid_s1_aready", s_aready[1], 0);
      tick();
      rst = 1'b1;
      s_avalid[0] = 1'b1;
      s_wvalid[0] = 1'b1; s_wvalid[1] = 1'b1;
      m_wready = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge axi_clk);
      chk("post_rst_m_avalid", m_avalid, 0);
      chk("post_rst_s0_aready", s_aready[0], 0);
      chk("post_rst_s1_aready", s_aready[1], 0);
      chk("post_rst_m_wvalid", m_wvalid, 0);
      chk("post_rst_s0_wready", s_wready[0], 0);
      chk("post_rst_s1_wready", s_wready[1], 0);
      chk("post_rst_busy", busy, 0);
      m_aready = 1'b1;
      tick();
      @(negedge axi_clk);
      chk("post_rst_grant_id7", m_aid[7], 0);
      chk("post_rst_grant_aready", s_aready[0], 1);
      tick();
      idle_all();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
